// File: rtl/error_diffusion.sv
// error_diffusion: Floyd-Steinberg style error-diffusion kernel for one pixel.
//
// A valid_i pulse marks the center pixel on data_i. The next four cycles carry,
// in this order, the right, lower-right, lower-center and lower-left neighbours.
// The center is binarised against Thresh. The quantisation error is then spread
// onto the neighbours with weights 7/16, 1/16, 5/16 and 3/16, and each result
// is saturated to 0..255.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   valid_i  one-cycle start pulse; data_i in that cycle is the center pixel
//   data_i   8-bit unsigned pixel sample
//   result0  binarised center (0 or 255)
//   result1  updated right neighbour        (x+1, y)
//   result2  updated lower-right neighbour  (x+1, y+1)
//   result3  updated lower-center neighbour (x,   y+1)
//   result4  updated lower-left neighbour   (x-1, y+1)
//   done     high for exactly one cycle when all five results are valid
//
// Configuration macro:
//   ED_ROUND_EN  when defined, the weighted error is rounded half up,
//                i.e. (err*w + 8) >>> 4. When undefined it is floored,
//                i.e. (err*w) >>> 4. Timing, ports and result0 are the same
//                either way.
module error_diffusion #(
  parameter int unsigned Thresh = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] result0,
  output logic [7:0] result1,
  output logic [7:0] result2,
  output logic [7:0] result3,
  output logic [7:0] result4,
  output logic       done
);

  localparam logic [7:0] ThreshB = 8'(Thresh);

  typedef enum logic [2:0] {
    StIdle,
    StCap1,
    StCap2,
    StCap3,
    StCap4,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic signed [8:0] err_q, err_d;
  logic [7:0]        res0_d;
  logic              start;
  logic [3:0]        weight;
  logic [7:0]        diffused;

  // A new sequence may only begin from IDLE or FIN; pulses in CAP1..CAP4 are ignored.
  assign start = valid_i && ((state_q == StIdle) || (state_q == StFin));

  always_comb begin
    state_d = state_q;
    weight  = 4'd0;
    unique case (state_q)
      StIdle: if (valid_i) state_d = StCap1;
      StCap1: begin state_d = StCap2; weight = 4'd7; end
      StCap2: begin state_d = StCap3; weight = 4'd1; end
      StCap3: begin state_d = StCap4; weight = 4'd5; end
      StCap4: begin state_d = StFin;  weight = 4'd3; end
      StFin:  state_d = valid_i ? StCap1 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Center binarisation and its signed error (-128..127).
  always_comb begin
    res0_d = (data_i >= ThreshB) ? 8'd255 : 8'd0;
    err_d  = $signed({1'b0, data_i}) - $signed({1'b0, res0_d});
  end

  // Weighted error added to the current neighbour sample, all in signed 13-bit.
  logic signed [12:0] err_ext, prod, adj, shifted, sum;
  always_comb begin
    err_ext = {{4{err_q[8]}}, err_q};
    prod    = err_ext * $signed({9'd0, weight});
`ifdef ED_ROUND_EN
    adj     = prod + 13'sd8;
`else
    adj     = prod;
`endif
    shifted = adj >>> 4;
    sum     = shifted + $signed({5'd0, data_i});
    if (sum < 13'sd0) begin
      diffused = 8'd0;
    end else if (sum > 13'sd255) begin
      diffused = 8'd255;
    end else begin
      diffused = sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= '0;
      result0 <= '0;
      result1 <= '0;
      result2 <= '0;
      result3 <= '0;
      result4 <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        result0 <= res0_d;
        err_q   <= err_d;
      end
      case (state_q)
        StCap1:  result1 <= diffused;
        StCap2:  result2 <= diffused;
        StCap3:  result3 <= diffused;
        StCap4:  result4 <= diffused;
        default: ;
      endcase
    end
  end

  assign done = (state_q == StFin);

endmodule
